writeback_commit_unit: RTL and testbench

- Receives completed results from the Branch and Memory execution pipelines, which the issue stage feeds as a dual-issue pair.
- Retires results to the two register-file write ports strictly in program order.
- Holds a small tagged completion buffer. The issue stage allocates a pair of consecutive tags per issued pair; pipelines return results out of order; up to 2 entries commit per cycle.

---
 rtl/writeback_commit_unit_pkg.sv | 26 ++
 rtl/writeback_commit_unit_commit_select.sv | 32 +++
 rtl/writeback_commit_unit.sv | 174 +++++++++++++++++
 tb/tb_writeback_commit_unit.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_commit_unit_pkg.sv
// Shared sizes and payload types for the in-order writeback/commit unit.
package writeback_commit_unit_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned TAG_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = TAG_W + 1;
    localparam int unsigned RD_W  = 5;

    typedef struct packed {
        logic             alloc;
        logic             done;
        logic             we;
        logic [RD_W-1:0]  rd;
        logic [WIDTH-1:0] data;
    } wb_entry_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [RD_W-1:0]  rd;
        logic [WIDTH-1:0] data;
        logic             we;
    } wb_result_t;

endpackage

// File: rtl/writeback_commit_unit_commit_select.sv
// Picks up to two in-order retirees from the head of the completion buffer
// and derives the masked register-file write enables.
module wb_commit_select
    import writeback_commit_unit_pkg::*;
(
    input  wb_entry_t  head_entry_i,
    input  wb_entry_t  next_entry_i,
    output logic [1:0] slot_valid_o,
    output logic [1:0] wr_en_o,
    output logic [1:0] commit_cnt_o
);

    logic v0;
    logic v1;
    logic en0;
    logic en1;

    always_comb begin
        v0  = head_entry_i.alloc && head_entry_i.done;
        v1  = v0 && next_entry_i.alloc && next_entry_i.done;
        en0 = v0 && head_entry_i.we && (head_entry_i.rd != '0);
        en1 = v1 && next_entry_i.we && (next_entry_i.rd != '0);
        // Same destination in one cycle: the younger write must be the survivor.
        if (en0 && en1 && (head_entry_i.rd == next_entry_i.rd)) begin
            en0 = 1'b0;
        end
        slot_valid_o = {v1, v0};
        wr_en_o      = {en1, en0};
        commit_cnt_o = 2'(v0) + 2'(v1);
    end

endmodule

// File: rtl/writeback_commit_unit.sv
// Tagged completion buffer that accepts out-of-order pipeline results and
// retires up to two of them per cycle to the register file in program order.
module writeback_commit_unit
    import writeback_commit_unit_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       Alloc_valid,
    output logic                       Alloc_ready,
    output logic [TAG_W-1:0]           Alloc_tag,
    input  logic                       Branch_Result_valid,
    input  logic [TAG_W-1:0]           Branch_Result_tag,
    input  logic [RD_W-1:0]            Branch_Result_rd,
    input  logic [WIDTH-1:0]           Branch_Result_data,
    input  logic                       Branch_Result_RF_write_en,
    input  logic                       Memory_Result_valid,
    input  logic [TAG_W-1:0]           Memory_Result_tag,
    input  logic [RD_W-1:0]            Memory_Result_rd,
    input  logic [WIDTH-1:0]           Memory_Result_data,
    input  logic                       Memory_Result_RF_write_en,
    input  logic                       Flush,
    output logic [1:0]                 RF_Write_en_WB,
    output logic [1:0][RD_W-1:0]       RF_rd_WB,
    output logic [1:0][WIDTH-1:0]      RF_data_WB,
    output logic [1:0]                 Commit_count,
    output logic                       Empty,
    output logic                       Protocol_Error
);

    wb_entry_t              entries_q [DEPTH];
    wb_entry_t              entries_d [DEPTH];
    logic [TAG_W-1:0]       head_q, head_d, tail_q, tail_d;
    logic [TAG_W-1:0]       head_p1, tail_p1;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [1:0]             rf_we_q, rf_we_d;
    logic [1:0][RD_W-1:0]   rf_rd_q, rf_rd_d;
    logic [1:0][WIDTH-1:0]  rf_data_q, rf_data_d;
    logic [1:0]             commit_cnt_q, commit_cnt_d;
    logic                   empty_q, empty_d;
    logic                   ready_q, ready_d;
    logic                   err_q, err_d;

    wb_result_t             br_res, mem_res;
    logic [1:0]             slot_valid_c, wr_en_c, commit_cnt_c;
    logic                   alloc_acc_c, br_ok_c, mem_ok_c, mem_clash_c, err_hit_c;

    assign br_res  = '{valid: Branch_Result_valid, tag: Branch_Result_tag,
                       rd: Branch_Result_rd, data: Branch_Result_data,
                       we: Branch_Result_RF_write_en};
    assign mem_res = '{valid: Memory_Result_valid, tag: Memory_Result_tag,
                       rd: Memory_Result_rd, data: Memory_Result_data,
                       we: Memory_Result_RF_write_en};

    assign head_p1 = head_q + TAG_W'(1);
    assign tail_p1 = tail_q + TAG_W'(1);

    wb_commit_select u_sel (
        .head_entry_i (entries_q[head_p1 - TAG_W'(1)]),
        .next_entry_i (entries_q[head_p1]),
        .slot_valid_o (slot_valid_c),
        .wr_en_o      (wr_en_c),
        .commit_cnt_o (commit_cnt_c)
    );

    // Result legality is judged against registered state only.
    always_comb begin
        alloc_acc_c = Alloc_valid && ready_q;
        br_ok_c     = br_res.valid && entries_q[br_res.tag].alloc && !entries_q[br_res.tag].done;
        mem_clash_c = mem_res.valid && br_res.valid && (mem_res.tag == br_res.tag);
        mem_ok_c    = mem_res.valid && !mem_clash_c &&
                      entries_q[mem_res.tag].alloc && !entries_q[mem_res.tag].done;
        err_hit_c   = (br_res.valid && !br_ok_c) || (mem_res.valid && !mem_ok_c);
    end

    always_comb begin
        entries_d    = entries_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        rf_we_d      = '0;
        rf_rd_d      = rf_rd_q;
        rf_data_d    = rf_data_q;
        commit_cnt_d = '0;
        err_d        = err_q;
        if (Flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries_d[i].alloc = 1'b0;
                entries_d[i].done  = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (slot_valid_c[0]) begin
                entries_d[head_q].alloc = 1'b0;
                entries_d[head_q].done  = 1'b0;
                rf_rd_d[0]   = entries_q[head_q].rd;
                rf_data_d[0] = entries_q[head_q].data;
            end
            if (slot_valid_c[1]) begin
                entries_d[head_p1].alloc = 1'b0;
                entries_d[head_p1].done  = 1'b0;
                rf_rd_d[1]   = entries_q[head_p1].rd;
                rf_data_d[1] = entries_q[head_p1].data;
            end
            if (alloc_acc_c) begin
                entries_d[tail_q].alloc  = 1'b1;
                entries_d[tail_q].done   = 1'b0;
                entries_d[tail_p1].alloc = 1'b1;
                entries_d[tail_p1].done  = 1'b0;
            end
            if (br_ok_c) begin
                entries_d[br_res.tag].done = 1'b1;
                entries_d[br_res.tag].we   = br_res.we;
                entries_d[br_res.tag].rd   = br_res.rd;
                entries_d[br_res.tag].data = br_res.data;
            end
            if (mem_ok_c) begin
                entries_d[mem_res.tag].done = 1'b1;
                entries_d[mem_res.tag].we   = mem_res.we;
                entries_d[mem_res.tag].rd   = mem_res.rd;
                entries_d[mem_res.tag].data = mem_res.data;
            end
            head_d       = head_q + TAG_W'(commit_cnt_c);
            tail_d       = tail_q + (alloc_acc_c ? TAG_W'(2) : TAG_W'(0));
            count_d      = count_q + (alloc_acc_c ? CNT_W'(2) : CNT_W'(0)) - CNT_W'(commit_cnt_c);
            rf_we_d      = wr_en_c;
            commit_cnt_d = commit_cnt_c;
            err_d        = err_q | err_hit_c;
        end
        empty_d = (count_d == '0);
        ready_d = (count_d <= CNT_W'(DEPTH - 2));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            rf_we_q      <= '0;
            rf_rd_q      <= '0;
            rf_data_q    <= '0;
            commit_cnt_q <= '0;
            empty_q      <= 1'b1;
            ready_q      <= 1'b1;
            err_q        <= 1'b0;
        end else begin
            entries_q    <= entries_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            rf_we_q      <= rf_we_d;
            rf_rd_q      <= rf_rd_d;
            rf_data_q    <= rf_data_d;
            commit_cnt_q <= commit_cnt_d;
            empty_q      <= empty_d;
            ready_q      <= ready_d;
            err_q        <= err_d;
        end
    end

    assign Alloc_ready    = ready_q;
    assign Alloc_tag      = tail_q;
    assign RF_Write_en_WB = rf_we_q;
    assign RF_rd_WB       = rf_rd_q;
    assign RF_data_WB     = rf_data_q;
    assign Commit_count   = commit_cnt_q;
    assign Empty          = empty_q;
    assign Protocol_Error = err_q;

endmodule

// File: tb/tb_writeback_commit_unit.sv
// Directed bench for writeback_commit_unit with a program-order queue model.
module tb_writeback_commit_unit;
    import writeback_commit_unit_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  Alloc_valid = 1'b0;
    logic                  Alloc_ready;
    logic [TAG_W-1:0]      Alloc_tag;
    logic                  Branch_Result_valid = 1'b0;
    logic [TAG_W-1:0]      Branch_Result_tag = '0;
    logic [4:0]            Branch_Result_rd = '0;
    logic [WIDTH-1:0]      Branch_Result_data = '0;
    logic                  Branch_Result_RF_write_en = 1'b0;
    logic                  Memory_Result_valid = 1'b0;
    logic [TAG_W-1:0]      Memory_Result_tag = '0;
    logic [4:0]            Memory_Result_rd = '0;
    logic [WIDTH-1:0]      Memory_Result_data = '0;
    logic                  Memory_Result_RF_write_en = 1'b0;
    logic                  Flush = 1'b0;
    logic [1:0]            RF_Write_en_WB;
    logic [1:0][4:0]       RF_rd_WB;
    logic [1:0][WIDTH-1:0] RF_data_WB;
    logic [1:0]            Commit_count;
    logic                  Empty;
    logic                  Protocol_Error;

    writeback_commit_unit dut (
        .clk(clk), .rst_n(rst_n),
        .Alloc_valid(Alloc_valid), .Alloc_ready(Alloc_ready), .Alloc_tag(Alloc_tag),
        .Branch_Result_valid(Branch_Result_valid), .Branch_Result_tag(Branch_Result_tag),
        .Branch_Result_rd(Branch_Result_rd), .Branch_Result_data(Branch_Result_data),
        .Branch_Result_RF_write_en(Branch_Result_RF_write_en),
        .Memory_Result_valid(Memory_Result_valid), .Memory_Result_tag(Memory_Result_tag),
        .Memory_Result_rd(Memory_Result_rd), .Memory_Result_data(Memory_Result_data),
        .Memory_Result_RF_write_en(Memory_Result_RF_write_en),
        .Flush(Flush),
        .RF_Write_en_WB(RF_Write_en_WB), .RF_rd_WB(RF_rd_WB), .RF_data_WB(RF_data_WB),
        .Commit_count(Commit_count), .Empty(Empty), .Protocol_Error(Protocol_Error)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: in-flight tags in program order plus per-tag completion records.
    int          q[$];
    bit          m_done [DEPTH];
    bit          m_we   [DEPTH];
    logic [4:0]  m_rd   [DEPTH];
    logic [31:0] m_data [DEPTH];
    int          m_tail;
    bit          m_err;
    logic [1:0]  x_we;
    int          x_cnt;
    logic [4:0]  x_rd   [2];
    logic [31:0] x_data [2];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit in_flight(input int t);
        foreach (q[i]) if (q[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        q.delete();
        m_tail = 0;
        m_err  = 1'b0;
        x_we   = 2'b00;
        x_cnt  = 0;
        for (int i = 0; i < 2; i++) begin
            x_rd[i] = '0;
            x_data[i] = '0;
        end
        for (int i = 0; i < int'(DEPTH); i++) m_done[i] = 1'b0;
    endtask

    task automatic model_step();
        int n;
        bit en0, en1;
        int bt, mt;
        if (Flush) begin
            q.delete();
            m_tail = 0;
            x_we   = 2'b00;
            x_cnt  = 0;
            for (int i = 0; i < int'(DEPTH); i++) m_done[i] = 1'b0;
            return;
        end
        n = 0;
        if (q.size() > 0 && m_done[q[0]]) n = 1;
        if (n == 1 && q.size() > 1 && m_done[q[1]]) n = 2;
        en0 = (n >= 1) && m_we[q[0]] && (m_rd[q[0]] != 0);
        en1 = (n == 2) && m_we[q[1]] && (m_rd[q[1]] != 0);
        if (en0 && en1 && m_rd[q[0]] == m_rd[q[1]]) en0 = 1'b0;
        x_we  = {en1, en0};
        x_cnt = n;
        for (int s = 0; s < n; s++) begin
            x_rd[s]   = m_rd[q[s]];
            x_data[s] = m_data[q[s]];
        end
        bt = int'(Branch_Result_tag);
        mt = int'(Memory_Result_tag);
        if (Branch_Result_valid) begin
            if (in_flight(bt) && !m_done[bt]) begin
                m_done[bt] = 1'b1; m_we[bt] = Branch_Result_RF_write_en;
                m_rd[bt] = Branch_Result_rd; m_data[bt] = Branch_Result_data;
            end else m_err = 1'b1;
        end
        if (Memory_Result_valid) begin
            if (Branch_Result_valid && mt == bt) m_err = 1'b1;
            else if (in_flight(mt) && !m_done[mt]) begin
                m_done[mt] = 1'b1; m_we[mt] = Memory_Result_RF_write_en;
                m_rd[mt] = Memory_Result_rd; m_data[mt] = Memory_Result_data;
            end else m_err = 1'b1;
        end
        if (Alloc_valid && q.size() <= int'(DEPTH) - 2) begin
            q.push_back(m_tail);
            q.push_back((m_tail + 1) % int'(DEPTH));
            m_done[m_tail] = 1'b0;
            m_done[(m_tail + 1) % int'(DEPTH)] = 1'b0;
            m_tail = (m_tail + 2) % int'(DEPTH);
        end
        repeat (n) void'(q.pop_front());
    endtask

    task automatic compare_all();
        chk("alloc_ready", Alloc_ready, q.size() <= int'(DEPTH) - 2);
        chk("alloc_tag", Alloc_tag, m_tail);
        chk("empty", Empty, q.size() == 0);
        chk("rf_we", RF_Write_en_WB, x_we);
        chk("commit_count", Commit_count, x_cnt);
        chk("protocol_error", Protocol_Error, m_err);
        for (int p = 0; p < 2; p++) begin
            if (x_we[p]) begin
                chk("rf_rd", RF_rd_WB[p], x_rd[p]);
                chk("rf_data", RF_data_WB[p], x_data[p]);
            end
        end
    endtask

    // One clock: advance model on current inputs, clock DUT, compare, clear pulses.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
        Alloc_valid = 1'b0;
        Branch_Result_valid = 1'b0;
        Memory_Result_valid = 1'b0;
        Flush = 1'b0;
    endtask

    task automatic bres(input int t, input int rd, input int d, input bit we);
        Branch_Result_valid = 1'b1; Branch_Result_tag = TAG_W'(t);
        Branch_Result_rd = 5'(rd); Branch_Result_data = WIDTH'(d);
        Branch_Result_RF_write_en = we;
    endtask

    task automatic mres(input int t, input int rd, input int d, input bit we);
        Memory_Result_valid = 1'b1; Memory_Result_tag = TAG_W'(t);
        Memory_Result_rd = 5'(rd); Memory_Result_data = WIDTH'(d);
        Memory_Result_RF_write_en = we;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty", Empty, 1);
        chk("rst_ready", Alloc_ready, 1);
        chk("rst_tag", Alloc_tag, 0);
        chk("rst_we", RF_Write_en_WB, 2'b00);
        chk("rst_err", Protocol_Error, 0);
        chk("rst_cnt", Commit_count, 0);
        rst_n = 1'b1;

        // in-order pair
        Alloc_valid = 1'b1; tick();
        bres(0, 5, 'hA, 1); mres(1, 6, 'hB, 1); tick();
        tick();
        chk("pair_we", RF_Write_en_WB, 2'b11);
        chk("pair_rd0", RF_rd_WB[0], 5);
        chk("pair_rd1", RF_rd_WB[1], 6);
        chk("pair_d0", RF_data_WB[0], 'hA);
        chk("pair_d1", RF_data_WB[1], 'hB);
        chk("pair_cnt", Commit_count, 2);
        tick();
        chk("pair_empty", Empty, 1);
        chk("pair_we_off", RF_Write_en_WB, 2'b00);

        // out-of-order completion
        Alloc_valid = 1'b1; tick();
        mres(3, 9, 'h33, 1); tick();
        repeat (3) tick();
        chk("ooo_wait_cnt", Commit_count, 0);
        bres(2, 8, 'h22, 1); tick();
        chk("ooo_early_cnt", Commit_count, 0);
        tick();
        chk("ooo_cnt", Commit_count, 2);
        chk("ooo_d1", RF_data_WB[1], 'h33);

        // full occupancy and wrap-around
        Flush = 1'b1; tick();
        chk("flush_tag", Alloc_tag, 0);
        repeat (4) begin Alloc_valid = 1'b1; tick(); end
        chk("full_ready", Alloc_ready, 0);
        chk("full_empty", Empty, 0);
        Alloc_valid = 1'b1; tick();
        chk("full_reject_tag", Alloc_tag, 0);
        bres(0, 1, 'h100, 1); mres(1, 2, 'h101, 1); tick();
        tick();
        chk("wrap_cnt", Commit_count, 2);
        chk("wrap_ready", Alloc_ready, 1);
        chk("wrap_tag", Alloc_tag, 0);
        Alloc_valid = 1'b1; tick();
        bres(0, 10, 'h200, 1); mres(1, 11, 'h201, 1); tick();
        tick();
        chk("wrap_hold_cnt", Commit_count, 0);
        for (int t = 2; t < 8; t += 2) begin
            bres(t, t + 12, 'h300 + t, 1); mres(t + 1, t + 13, 'h301 + t, 1); tick();
        end
        repeat (4) tick();
        chk("wrap_drained", Empty, 1);

        // masking: same rd, then rd=0
        Alloc_valid = 1'b1; tick();
        bres(2, 7, 1, 1); mres(3, 7, 2, 1); tick();
        tick();
        chk("mask_we", RF_Write_en_WB, 2'b10);
        chk("mask_rd1", RF_rd_WB[1], 7);
        chk("mask_d1", RF_data_WB[1], 2);
        Alloc_valid = 1'b1; tick();
        bres(4, 0, 5, 1); mres(5, 0, 6, 1); tick();
        tick();
        chk("rd0_we", RF_Write_en_WB, 2'b00);
        chk("rd0_cnt", Commit_count, 2);

        // protocol errors
        bres(6, 1, 1, 1); tick();
        chk("err_unalloc", Protocol_Error, 1);
        chk("err_empty", Empty, 1);
        Alloc_valid = 1'b1; tick();
        bres(6, 3, 'h66, 1); mres(6, 4, 'h67, 1); tick();
        mres(7, 4, 'h77, 0); tick();
        bres(7, 4, 'h78, 1); tick();
        repeat (2) tick();
        chk("err_sticky", Protocol_Error, 1);

        // flush with three pairs in flight
        repeat (3) begin Alloc_valid = 1'b1; tick(); end
        bres(0, 5, 'h5, 1); tick();
        Flush = 1'b1; Alloc_valid = 1'b1; bres(1, 6, 'h6, 1); tick();
        chk("fl_empty", Empty, 1);
        chk("fl_tag", Alloc_tag, 0);
        chk("fl_we", RF_Write_en_WB, 2'b00);
        tick();
        chk("fl_we2", RF_Write_en_WB, 2'b00);

        // asynchronous reset mid-operation
        Alloc_valid = 1'b1; tick();
        bres(0, 3, 'h30, 1); mres(1, 4, 'h40, 1); tick();
        tick();
        chk("pre_rst_we", RF_Write_en_WB, 2'b11);
        rst_n = 1'b0;
        #1;
        chk("arst_we", RF_Write_en_WB, 2'b00);
        chk("arst_cnt", Commit_count, 0);
        chk("arst_err", Protocol_Error, 0);
        chk("arst_empty", Empty, 1);
        chk("arst_rd0", RF_rd_WB[0], 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        Alloc_valid = 1'b1; tick();
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
